// File: rtl/mul_8bit_seq.sv
// Sequential unsigned shift-add multiplier for the 8-bit MIPS datapath.
// The shared ripple adder is external: this block drives Add_A/Add_B/Add_Cin
// and folds Add_Sum/Add_Cout back into the accumulator on every iteration.
module mul_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     Add_A,
    output logic [WIDTH-1:0]     Add_B,
    output logic                 Add_Cin,
    input  logic [WIDTH-1:0]     Add_Sum,
    input  logic                 Add_Cout,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [WIDTH-1:0]     m;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;
    logic                 accept;

    // Add-then-shift: the adder carry lands in the MSB, so nothing is lost.
    assign acc_next  = {Add_Cout, Add_Sum, acc[WIDTH-1:1]};
    assign last_iter = (cnt == LAST_ITER);
    // A new request is taken only when no iteration is in flight.
    assign accept    = Start && (state != BUSY);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and adder/handshake outputs.
    always_comb begin
        next_state = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        Add_A      = '0;
        Add_B      = '0;
        Add_Cin    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) next_state = BUSY;
            end
            BUSY: begin
                Busy  = 1'b1;
                Add_A = acc[2*WIDTH-1:WIDTH];
                Add_B = acc[0] ? m : '0;
                if (last_iter) next_state = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                next_state = Start ? BUSY : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m       <= '0;
            acc     <= '0;
            cnt     <= '0;
            Product <= '0;
        end else if (accept) begin
            m   <= A;
            acc <= {{WIDTH{1'b0}}, B};
            cnt <= '0;
        end else if (state == BUSY) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last_iter) Product <= acc_next;
        end
    end

endmodule

// File: doc/mul_8bit_seq.md
Name: mul_8bit_seq

Overview:
- Multi-cycle unsigned shift-add multiplier for the 8-bit MIPS datapath.
- Sits directly upstream of the 8-bit ripple adder.
  - Drives the adder's A/B/Cin with the partial-product high half and the multiplicand.
  - Consumes the adder's Sum/Cout each cycle.
- Produces a 16-bit product into the HI/LO result path after a fixed number of iterations.
- Uses a start/busy/done handshake so the control unit can stall on MULT.

Parameters:
WIDTH, 8, operand width; the product is 2*WIDTH bits wide.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
Start  input  1  request pulse; sampled only in IDLE or DONE
A  input  WIDTH  multiplicand; latched when Start is accepted
B  input  WIDTH  multiplier; latched when Start is accepted
Add_A  output  WIDTH  adder operand A (current high half of accumulator)
Add_B  output  WIDTH  adder operand B (multiplicand if current LSB is 1, else 0)
Add_Cin  output  1  adder carry-in; tied to 0
Add_Sum  input  WIDTH  adder sum result
Add_Cout  input  1  adder carry-out
Busy  output  1  high while iterating
Done  output  1  one-cycle pulse when Product becomes valid
Product  output  2*WIDTH  result; held until the next accepted Start

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE.
  - Accumulator, multiplicand register, iteration counter and Product all clear to 0.
  - Busy=0, Done=0.
  - Add_A, Add_B and Add_Cin read 0.
- Internal registers:
  - M[WIDTH-1:0]: multiplicand.
  - ACC[2*WIDTH-1:0]: high half is the partial sum, low half is the remaining multiplier bits.
  - CNT: iteration counter, ceil(log2(WIDTH+1)) bits.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Busy=0, Done=0.
  - If Start=1 at a clock edge: M<=A, ACC<={0,B}, CNT<=0, go to BUSY.
  - If Start=0, stay in IDLE.
- BUSY (Busy=1):
  - Combinationally: Add_A=ACC[2W-1:W]; Add_B = ACC[0] ? M : 0; Add_Cin=0.
  - Each edge: ACC <= {Add_Cout, Add_Sum, ACC[W-1:1]} (add, then shift right by one); CNT <= CNT+1.
  - When CNT reaches WIDTH-1 and that iteration completes, go to DONE. Exactly WIDTH iterations are performed.
  - Start is ignored in BUSY. A, B, M and the product are unaffected.
- DONE:
  - Done=1 for exactly one cycle; Busy=0.
  - Product equals ACC from entry into DONE onward, and is not updated again until DONE is next reached.
  - If Start=1 in DONE, it is accepted as in IDLE and the next state is BUSY (back-to-back operation). Otherwise the next state is IDLE.
- Latency: Start accepted at edge 0; Done is high in the cycle after edge WIDTH (edge 8 for WIDTH=8); Product is valid from that cycle.
- Arithmetic:
  - Unsigned only.
  - Add_Cout is captured as the accumulator MSB each iteration, so no overflow is possible. Full range: 0xFF*0xFF = 0xFE01.
- Outside BUSY, Add_A and Add_B read 0 so the shared adder is quiescent.

Test Plan:
- Reset, then A=13, B=11, Start pulse:
  - Busy high for 8 cycles.
  - Done pulses 1 cycle after the 8th edge.
  - Product=0x008F and stays 0x008F afterwards.
- A=0xFF, B=0xFF → Product=0xFE01; Add_Cout=1 is observed on at least one iteration and is absorbed into Product.
- A=0x00, B=0xA5 → Product=0x0000; A=0x5A, B=0x00 → Product=0x0000; Add_B=0 on every iteration of the second case.
- A=3, B=4 started, then Start re-pulsed with A=9, B=9 during BUSY → second request ignored; Product=0x000C.
- Start held high through DONE with A=2, B=7, then A=5, B=5 presented at DONE → results 0x000E then 0x0019; no IDLE cycle between the two operations.
- Assert reset at iteration 4 of A=0xF0, B=0x0F:
  - Busy, Done and Product go to 0 immediately (asynchronously).
  - A following Start with A=1, B=1 yields Product=0x0001.
